// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port out of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a byte stream into 32-bit words and writes them to instruction memory
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDR_W:0]  len_words,
    imem_loader_if.slave     bus,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        idx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              len_ok;
    logic              last_word;
    logic              take;

    assign len_ok    = (len_words != '0) && (len_words <= DEPTH_W);
    assign last_word = ({1'b0, addr_q} == (len_q - (ADDR_W+1)'(1)));
    assign take      = bus.s_valid && bus.s_ready;

    // One bubble per word: no byte is taken while the packed word is being written.
    assign bus.s_ready   = (state == LOAD) && !we_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state == LOAD);
    assign done          = (state == DONE);
    assign core_rst      = (state == DONE);
    assign err           = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = len_ok ? LOAD : IDLE;
                end
            end
            LOAD: begin
                if (we_q && last_word) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q   <= '0;
            idx     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_q <= !len_ok;
                        if (len_ok) begin
                            len_q   <= len_words;
                            addr_q  <= '0;
                            idx     <= '0;
                            wdata_q <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (take) begin
                        wdata_q[{idx, 3'b000} +: 8] <= bus.s_data;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            we_q <= 1'b1;
                        end
                    end
                    // Address stays on the final word so it never passes len-1.
                    if (we_q && !last_word) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
